key_conditioner: RTL and testbench



---
 rtl/key_conditioner.sv | 140 ++++++++++++++
 tb/tb_key_conditioner.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: conditions NUM_KEYS active-low asynchronous push-buttons.
// Each channel has a two-flop synchronizer, a debounce counter and an edge
// detector. The outputs are a clean active-high level and one-cycle
// press/release pulses.
//
// Optional feature: define KEY_AUTOREPEAT_EN to make press repeat while a
// key stays held. The first repeat comes REPEAT_DELAY cycles after the
// original press, and later repeats come every REPEAT_PERIOD cycles.
//
// Ports:
//   clock          the only clock; all state updates on its rising edge
//   reset          synchronous, active-high
//   key_n          raw asynchronous keys, active-low (0 = pressed)
//   level          debounced key state, 1 = pressed (registered)
//   press          one-cycle pulse on an accepted press or repeat (registered)
//   release_pulse  one-cycle pulse on an accepted release (registered);
//                  `release` is a reserved word, hence the longer name
//   any_level      OR of all level bits (combinational from level)
module key_conditioner #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] level,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic                any_level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject illegal parameter sets at elaboration.
  if (NUM_KEYS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("key_conditioner: all parameters must be at least 1");
  end

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [CNT_W-1:0]    db_cnt     [NUM_KEYS];
  logic [CNT_W-1:0]    db_cnt_nxt [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_nxt;
  logic [NUM_KEYS-1:0] press_nxt;
  logic [NUM_KEYS-1:0] release_nxt;

  // Debounce: count consecutive mismatch cycles and accept on the last one.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      level_nxt[k]  = level[k];
      db_cnt_nxt[k] = '0;
      if (sync2[k] != level[k]) begin
        if (db_cnt[k] == CNT_LAST) begin
          level_nxt[k] = ~level[k];
        end else begin
          db_cnt_nxt[k] = db_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0]    rpt_cnt       [NUM_KEYS];
  logic [RPT_W-1:0]    rpt_cnt_nxt   [NUM_KEYS];
  logic [NUM_KEYS-1:0] rpt_armed;
  logic [NUM_KEYS-1:0] rpt_armed_nxt;
  logic [NUM_KEYS-1:0] rpt_fire;

  // Repeat timer: runs only while level stays 1, so it never fires on the
  // release cycle. rpt_armed selects the period once the initial delay has passed.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      rpt_cnt_nxt[k]   = '0;
      rpt_armed_nxt[k] = 1'b0;
      rpt_fire[k]      = 1'b0;
      if (level[k] && level_nxt[k]) begin
        rpt_armed_nxt[k] = rpt_armed[k];
        if (rpt_cnt[k] == (rpt_armed[k] ? PER_LAST : DLY_LAST)) begin
          rpt_fire[k]      = 1'b1;
          rpt_armed_nxt[k] = 1'b1;
        end else begin
          rpt_cnt_nxt[k] = rpt_cnt[k] + RPT_W'(1);
        end
      end
    end
  end

  assign press_nxt = (level_nxt & ~level) | rpt_fire;
`else
  assign press_nxt = level_nxt & ~level;
`endif

  assign release_nxt = ~level_nxt & level;

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1         <= '0;
      sync2         <= '0;
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        db_cnt[k] <= '0;
      end
`ifdef KEY_AUTOREPEAT_EN
      rpt_armed <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        rpt_cnt[k] <= '0;
      end
`endif
    end else begin
      sync1         <= ~key_n;
      sync2         <= sync1;
      level         <= level_nxt;
      press         <= press_nxt;
      release_pulse <= release_nxt;
      for (int k = 0; k < NUM_KEYS; k++) begin
        db_cnt[k] <= db_cnt_nxt[k];
      end
`ifdef KEY_AUTOREPEAT_EN
      rpt_armed <= rpt_armed_nxt;
      for (int k = 0; k < NUM_KEYS; k++) begin
        rpt_cnt[k] <= rpt_cnt_nxt[k];
      end
`endif
    end
  end

  assign any_level = |level;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed bench for key_conditioner with NUM_KEYS=4,
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10 and REPEAT_PERIOD=3.
// Edge numbers count from the first edge that samples a new key_n value.
// Outputs are sampled 1 time unit after each rising edge.
module tb_key_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] release_pulse;
  logic       any_level;

  int n_checks = 0;
  int n_pass   = 0;

  key_conditioner #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .key_n        (key_n),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .any_level    (any_level)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic exp_p;

    // Reset state.
    reset = 1'b1;
    key_n = 4'hF;
    tick();
    tick();
    check("rst_level", 32'(level), 32'h0);
    check("rst_press", 32'(press), 32'h0);
    check("rst_release", 32'(release_pulse), 32'h0);
    check("rst_any", 32'(any_level), 32'h0);
    reset = 1'b0;
    tick();
    tick();

    // Clean press on key 0, then release.
    key_n = 4'b1110;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("clean_press_e%0d", e), 32'(press), (e == 6) ? 32'h1 : 32'h0);
      check($sformatf("clean_level_e%0d", e), 32'(level), (e >= 6) ? 32'h1 : 32'h0);
      check($sformatf("clean_any_e%0d", e), 32'(any_level), (e >= 6) ? 32'h1 : 32'h0);
    end
    key_n = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("clean_rel_e%0d", e), 32'(release_pulse), (e == 6) ? 32'h1 : 32'h0);
      check($sformatf("clean_rlevel_e%0d", e), 32'(level), (e < 6) ? 32'h1 : 32'h0);
      check($sformatf("clean_rpress_e%0d", e), 32'(press), 32'h0);
    end

    // Bounce rejection on key 1: low 3, high 1, low 3, then high.
    for (int e = 1; e <= 14; e++) begin
      key_n = ((e >= 1 && e <= 3) || (e >= 5 && e <= 7)) ? 4'b1101 : 4'b1111;
      tick();
      check($sformatf("bounce_level_e%0d", e), 32'(level), 32'h0);
      check($sformatf("bounce_press_e%0d", e), 32'(press), 32'h0);
    end

    // All four keys pressed at once, then released at once.
    key_n = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("simul_press_e%0d", e), 32'(press), (e == 6) ? 32'hF : 32'h0);
      check($sformatf("simul_any_e%0d", e), 32'(any_level), (e >= 6) ? 32'h1 : 32'h0);
    end
    key_n = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("simul_rel_e%0d", e), 32'(release_pulse), (e == 6) ? 32'hF : 32'h0);
    end

    // Reset mid-debounce on key 2; the key is held through reset.
    key_n = 4'b1011;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("rstmid_pre_e%0d", e), 32'(press), 32'h0);
    end
    reset = 1'b1;
    tick();
    check("rstmid_level", 32'(level), 32'h0);
    check("rstmid_press", 32'(press), 32'h0);
    check("rstmid_release", 32'(release_pulse), 32'h0);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("rstmid_press_e%0d", e), 32'(press), (e == 6) ? 32'h4 : 32'h0);
      check($sformatf("rstmid_level_e%0d", e), 32'(level), (e >= 6) ? 32'h4 : 32'h0);
    end
    key_n = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      tick();
    end
    check("rstmid_idle", 32'(level), 32'h0);

    // Key 3 held for 30 cycles: auto-repeat or a single press.
    key_n = 4'b0111;
    for (int e = 1; e <= 42; e++) begin
      if (e == 31) key_n = 4'b1111;
      tick();
`ifdef KEY_AUTOREPEAT_EN
      exp_p = (e == 6) || (e >= 16 && e <= 34 && ((e - 16) % 3) == 0);
`else
      exp_p = (e == 6);
`endif
      check($sformatf("rpt_press_e%0d", e), 32'(press), exp_p ? 32'h8 : 32'h0);
      check($sformatf("rpt_rel_e%0d", e), 32'(release_pulse), (e == 36) ? 32'h8 : 32'h0);
      check($sformatf("rpt_level_e%0d", e), 32'(level), (e >= 6 && e < 36) ? 32'h8 : 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
